// File: rtl/digit_uart_tx_pkg.sv
// rtl/digit_uart_tx_pkg.sv - shared ASCII constants, serializer state encoding and digit mapping
package digit_uart_tx_pkg;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_DASH = 8'h2D;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Out-of-range codes become '-' to match the display receiver's invalid marker
  function automatic logic [7:0] digit_to_ascii(input logic [3:0] d);
    return (d <= 4'd9) ? (ASCII_ZERO + {4'b0000, d}) : ASCII_DASH;
  endfunction

endpackage

// File: rtl/digit_uart_tx_if.sv
// rtl/digit_uart_tx_if.sv - digit valid/ready handshake bundle
interface digit_uart_tx_if;
  logic [3:0] digit;
  logic       digit_valid;
  logic       digit_ready;

  modport master (output digit, output digit_valid, input  digit_ready);
  modport slave  (input  digit, input  digit_valid, output digit_ready);
endinterface

// File: rtl/digit_uart_tx_uart_tx_8n1.sv
// rtl/digit_uart_tx_uart_tx_8n1.sv - 8N1 byte serializer with baud counter
module uart_tx_8n1
  import digit_uart_tx_pkg::*;
#(
  parameter int DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_byte,
  output logic       uarttx,
  output logic       done,
  output logic       idle
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  tx_state_t     state, state_nxt;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          line;
  logic          baud_last;

  assign baud_last = (baud_cnt == CW'(DIV - 1));
  assign done      = (state == STOP) && baud_last;
  assign idle      = (state == IDLE);

  always_comb begin
    state_nxt = state;
    line      = 1'b1;
    case (state)
      IDLE:  if (start) state_nxt = START;
      START: begin
        line = 1'b0;
        if (baud_last) state_nxt = DATA;
      end
      DATA: begin
        line = shreg[0];
        if (baud_last && bit_idx == 3'd7) state_nxt = STOP;
      end
      STOP: if (baud_last) state_nxt = start ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // uarttx is the line value of the current state registered, so it trails the FSM by one clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uarttx   <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      shreg    <= 8'h00;
    end else begin
      uarttx   <= line;
      baud_cnt <= (state == IDLE || baud_last) ? '0 : baud_cnt + 1'b1;
      if (state == DATA && baud_last) begin
        bit_idx <= bit_idx + 3'd1;
        shreg   <= {1'b0, shreg[7:1]};
      end
      if (start && (idle || done)) shreg <= tx_byte;
    end
  end

endmodule

// File: rtl/digit_uart_tx.sv
// rtl/digit_uart_tx.sv - digit handshake, ASCII mapping and CR/LF sequencing onto a UART TX line
module digit_uart_tx
  import digit_uart_tx_pkg::*;
#(
  parameter int CLK_HZ      = 12000000,
  parameter int BAUD        = 9600,
  parameter int APPEND_CRLF = 1
) (
  input  logic            clk,
  input  logic            rst,
  digit_uart_tx_if.slave  dig,
  output logic            uarttx,
  output logic            busy
);

  localparam int         DIV       = CLK_HZ / BAUD;
  localparam logic [1:0] LAST_CHAR = (APPEND_CRLF != 0) ? 2'd2 : 2'd0;

  logic       idle;
  logic       done;
  logic       accept;
  logic       more;
  logic       start;
  logic [1:0] char_idx;
  logic [7:0] tx_byte;

  assign dig.digit_ready = idle;
  assign busy            = ~idle;
  assign accept          = dig.digit_valid & idle;
  assign more            = (char_idx != LAST_CHAR);
  assign start           = accept | (done & more);

  // While idle the mapped digit is offered; mid-message the char after char_idx is offered
  always_comb begin
    tx_byte = digit_to_ascii(dig.digit);
    if (!idle) begin
      case (char_idx)
        2'd0:    tx_byte = ASCII_CR;
        default: tx_byte = ASCII_LF;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              char_idx <= 2'd0;
    else if (accept)      char_idx <= 2'd0;
    else if (done & more) char_idx <= char_idx + 2'd1;
  end

  uart_tx_8n1 #(.DIV(DIV)) u_ser (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .tx_byte (tx_byte),
    .uarttx  (uarttx),
    .done    (done),
    .idle    (idle)
  );

endmodule

// File: tb/tb_digit_uart_tx.sv
// tb/tb_digit_uart_tx.sv - self-checking bench: vector table, frame-decoding scoreboard, corner sequences
module tb_digit_uart_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx0, tx1, busy0, busy1;

  digit_uart_tx_if if0();
  digit_uart_tx_if if1();

  digit_uart_tx #(.CLK_HZ(16), .BAUD(1), .APPEND_CRLF(0)) dut0 (
    .clk(clk), .rst(rst), .dig(if0), .uarttx(tx0), .busy(busy0));
  digit_uart_tx #(.CLK_HZ(16), .BAUD(1), .APPEND_CRLF(1)) dut1 (
    .clk(clk), .rst(rst), .dig(if1), .uarttx(tx1), .busy(busy1));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rst_epoch = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  typedef struct {
    logic [3:0] digit;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[6];

  always @(posedge rst) rst_epoch <= rst_epoch + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic txk(input int k);
    return (k != 0) ? tx1 : tx0;
  endfunction
  function automatic logic busyk(input int k);
    return (k != 0) ? busy1 : busy0;
  endfunction
  function automatic logic readyk(input int k);
    return (k != 0) ? if1.digit_ready : if0.digit_ready;
  endfunction

  task automatic drive(input int k, input logic [3:0] d, input logic v);
    if (k != 0) begin if1.digit = d; if1.digit_valid = v; end
    else        begin if0.digit = d; if0.digit_valid = v; end
  endtask

  // Decodes each frame by sampling bit centres and compares against the expected-byte queue
  task automatic mon(input int k);
    int ep;
    int exp;
    logic [7:0] b;
    logic stp;
    forever begin
      @(negedge clk);
      if (!rst && txk(k) == 1'b0) begin
        ep = rst_epoch;
        b  = 8'h00;
        repeat (7) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (16) @(negedge clk);
          b[i] = txk(k);
        end
        repeat (16) @(negedge clk);
        stp = txk(k);
        if (ep == rst_epoch && !rst) begin
          exp = -1;
          if (k != 0) begin if (q1.size() > 0) exp = int'(q1.pop_front()); end
          else        begin if (q0.size() > 0) exp = int'(q0.pop_front()); end
          chk($sformatf("frame byte dut%0d", k), int'(b), exp);
          chk($sformatf("stop bit dut%0d", k), int'(stp), 1);
        end
      end
    end
  endtask

  initial mon(0);
  initial mon(1);

  task automatic do_accept(input int k, input logic [3:0] d, input bit drop);
    int n;
    n = 0;
    @(negedge clk);
    while (!readyk(k) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) chk("ready timeout", 0, 1);
    drive(k, d, 1'b1);
    @(posedge clk);
    #1;
    if (drop) drive(k, d, 1'b0);
  endtask

  // Called right after an accepting edge: latency, busy length and ready return
  task automatic check_msg(input int k, input int nch);
    int cnt;
    @(negedge clk);
    chk("ready low after accept", int'(readyk(k)), 0);
    chk("busy high after accept", int'(busyk(k)), 1);
    chk("line high one cycle after accept", int'(txk(k)), 1);
    @(negedge clk);
    chk("start bit falls", int'(txk(k)), 0);
    cnt = 2;
    forever begin
      @(negedge clk);
      if (!busyk(k) || cnt >= 5000) break;
      cnt++;
    end
    chk($sformatf("busy length dut%0d", k), cnt, 160 * nch);
    chk("ready back in idle", int'(readyk(k)), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int cnt;
    int bad;
    vecs[0] = '{4'd5,  8'h35};
    vecs[1] = '{4'd12, 8'h2D};
    vecs[2] = '{4'd0,  8'h30};
    vecs[3] = '{4'd9,  8'h39};
    vecs[4] = '{4'd10, 8'h2D};
    vecs[5] = '{4'd15, 8'h2D};

    drive(0, 4'd0, 1'b0);
    drive(1, 4'd0, 1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset tx0", int'(tx0), 1);
    chk("reset busy0", int'(busy0), 0);
    chk("reset ready0", int'(if0.digit_ready), 1);
    chk("reset tx1", int'(tx1), 1);
    chk("reset busy1", int'(busy1), 0);
    chk("reset ready1", int'(if1.digit_ready), 1);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      q0.push_back(vecs[i].exp);
      do_accept(0, vecs[i].digit, 1'b1);
      check_msg(0, 1);
    end

    q1.push_back(8'h30); q1.push_back(8'h0D); q1.push_back(8'h0A);
    do_accept(1, 4'd0, 1'b1);
    check_msg(1, 3);
    q1.push_back(8'h2D); q1.push_back(8'h0D); q1.push_back(8'h0A);
    do_accept(1, 4'd11, 1'b1);
    check_msg(1, 3);

    // valid held high with digit changing; second accept must land on the first idle cycle
    q0.push_back(8'h33);
    do_accept(0, 4'd3, 1'b0);
    cnt = 0;
    forever begin
      @(negedge clk);
      if (if0.digit_ready || cnt >= 5000) break;
      cnt++;
      if (cnt == 5)   drive(0, 4'd9, 1'b1);
      if (cnt == 100) drive(0, 4'd8, 1'b1);
    end
    chk("cycles until second accept", cnt, 160);
    q0.push_back(8'h38);
    @(posedge clk);
    #1;
    drive(0, 4'd8, 1'b0);
    check_msg(0, 1);

    // reset during data bit 3 of 0x35 (a zero bit)
    q0.push_back(8'h35);
    do_accept(0, 4'd5, 1'b1);
    repeat (73) @(negedge clk);
    chk("data bit3 low before reset", int'(tx0), 0);
    rst = 1'b1;
    #1;
    chk("async reset tx", int'(tx0), 1);
    chk("async reset busy", int'(busy0), 0);
    chk("async reset ready", int'(if0.digit_ready), 1);
    q0.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx0 !== 1'b1 || busy0 !== 1'b0 || tx1 !== 1'b1 || busy1 !== 1'b0) bad++;
    end
    chk("idle line after reset", bad, 0);

    q0.push_back(8'h37);
    do_accept(0, 4'd7, 1'b1);
    check_msg(0, 1);

    repeat (20) @(negedge clk);
    chk("dut0 queue drained", q0.size(), 0);
    chk("dut1 queue drained", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
